// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/colour timing generator with pixel-clock enable
// Optional colour-bar source enabled by defining VGA_TESTPATTERN_EN.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2
) (
  input  logic        CLK_50,
  input  logic        RST,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  input  logic [11:0] pix_rgb,
  input  logic        test_pattern,
  output logic        frame_start,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]  div_q, div_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        pe;
  logic        active;
  logic [11:0] src_rgb;

`ifdef VGA_TESTPATTERN_EN
  localparam int          BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam logic [10:0] BAR_W11 = 11'(BAR_W);

  // Bar order white..black maps each channel to one inverted bit of the bar index.
  logic [2:0]  bar_sel;
  logic [11:0] bar_rgb;

  assign bar_sel = 3'(hcnt_q / BAR_W11);
  assign bar_rgb = {{4{~bar_sel[1]}}, {4{~bar_sel[2]}}, {4{~bar_sel[0]}}};
  assign src_rgb = test_pattern ? bar_rgb : pix_rgb;
`else
  logic unused_test_pattern;

  assign unused_test_pattern = test_pattern;
  assign src_rgb             = pix_rgb;
`endif

  assign pe     = (div_q == DIV_LAST);
  assign active = ({1'b0, hcnt_q} < H_ACT) && ({1'b0, vcnt_q} < V_ACT);

  always_comb begin
    div_d  = pe ? 4'd0 : div_q + 4'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pe) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
    end
  end

  always_comb begin
    rgb_d = active ? src_rgb : 12'h000;
    hs_d  = ((hcnt_q >= H_SYNC_LO) && (hcnt_q <= H_SYNC_HI)) ? HS_POL : ~HS_POL;
    vs_d  = ((vcnt_q >= V_SYNC_LO) && (vcnt_q <= V_SYNC_HI)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      rgb_q  <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      // Colour and both syncs share one enable so they stay aligned.
      if (pe) begin
        rgb_q <= rgb_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
      end
    end
  end

  assign pix_x       = hcnt_q;
  assign pix_y       = vcnt_q;
  assign pix_req     = pe && active;
  assign frame_start = pe && (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA horizontal and vertical timing from the 50 MHz board clock using an internal pixel-clock enable. It fetches pixel colour through a per-pixel request interface and drives registered 4-bit R/G/B plus HS/VS. The outputs connect directly to the board's VGA output pins, which feed the virtual VGA monitor in simulation. It sits between the user's frame buffer or pattern source and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CLK_DIV, 2, CLK_50 cycles per pixel; legal range 1..16
Constraints: H_TOTAL = sum of the H_* parameters and must be ≤ 2048. V_TOTAL = sum of the V_* parameters and must be ≤ 2048.

Ports:
CLK_50  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
pix_req  output  1  one-cycle strobe: colour for (pix_x, pix_y) is sampled this cycle
pix_x  output  11  current horizontal counter; valid as an address while pix_req-period is active
pix_y  output  11  current vertical counter
pix_rgb  input  12  {R[3:0], G[3:0], B[3:0]}; sampled only when pix_req=1
test_pattern  input  1  selects internal colour bars (only with the optional feature)
frame_start  output  1  one-cycle pulse at the start of each frame
VGA_R, VGA_G, VGA_B  output  4 each  registered colour
VGA_HS  output  1  registered hsync
VGA_VS  output  1  registered vsync

Behaviour:
- Divider div counts 0..CLK_DIV-1 and wraps. pe = (div == CLK_DIV-1). With CLK_DIV=1, pe is constantly 1.
- Counters hcnt and vcnt advance only on pe:
  - hcnt increments and wraps from H_TOTAL-1 to 0.
  - On an hcnt wrap, vcnt increments and wraps from V_TOTAL-1 to 0.
- pix_x = hcnt and pix_y = vcnt, combinational from the counters. They are stable for CLK_DIV cycles, so a 1-cycle synchronous RAM can be used when CLK_DIV ≥ 2.
- active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- pix_req = pe && active. The consumer must present pix_rgb in that same cycle.
- Output stage updates only on pe:
  - VGA_R/G/B <= active ? pix_rgb fields : 0.
  - VGA_HS <= (hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) ? HS_POL : ~HS_POL.
  - VGA_VS follows the same rule using vcnt and the V_* parameters.
- Latency: colour and syncs for counter position P appear on the outputs one pixel period after P. Colour and syncs stay mutually aligned.
- frame_start = pe && hcnt==0 && vcnt==0, i.e. the same cycle pix_req fires for pixel (0,0).
- Reset values (next edge with RST=1):
  - div=0, hcnt=0, vcnt=0.
  - VGA_R/G/B=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - pix_req=0, frame_start=0; both are gated by pe and div=0, so this holds while CLK_DIV>1.
- Reset mid-frame: takes effect on the next edge, aborts the line, and restarts at (0,0). The first frame_start after release occurs CLK_DIV-1 cycles later.
- pix_rgb is ignored outside the active region. Blanking outputs are forced to 0 regardless of input.

Optional Feature:
VGA_TESTPATTERN_EN
- Defined: when test_pattern=1, pix_rgb is replaced by 8 vertical bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black, using 4'hF/4'h0 per channel. pix_req still pulses.
- Undefined: test_pattern is ignored and no bar logic is synthesised.

Test Plan:
- Reset: hold RST=1 for 5 cycles -> VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, pix_req=0. Release -> frame_start pulses at cycle CLK_DIV-1.
- Defaults, run 2 frames -> HS low for 192 CLK_50 cycles every 1600; VS low for 3200 cycles every 840000; frame_start period = 840000.
- Count pix_req per frame -> exactly 307200; max pix_x=639, max pix_y=479 while pix_req=1.
- Drive pix_rgb=12'hABC only at (0,0) and 12'h000 elsewhere -> VGA_R=A, G=B, B=C during exactly the one pixel period after the (0,0) pe, then 0.
- Assert RST for 1 cycle at (300,200) -> next edge gives hcnt=vcnt=0 and outputs reset. Timing restarts cleanly; the next HS falling edge is 656 pixels after release.
- With VGA_TESTPATTERN_EN defined and test_pattern=1 on line 0 -> pixels 0-79 = FFF, 80-159 = FF0, …, 560-639 = 000. Without the macro -> output equals pix_rgb.
